// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the N:1 handshake mux and its round-robin arbiter.
// rr_pick works on a fixed 64-channel frame, so arbiters built on it support N <= 64.
package mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   localparam int RR_MAX_N = 64;
   localparam int RR_IDX_W = 7;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] index;
   } rr_pick_t;

   // First valid index at or after ptr, wrapping modulo n. Scanning from the
   // far end means the closest hit is the last one written and therefore wins.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int                  n);
      rr_pick_t            pick;
      logic [RR_IDX_W:0]   idx;
      pick = '0;
      for (int k = RR_MAX_N - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = {1'b0, ptr} + (RR_IDX_W + 1)'(k);
            if (int'(idx) >= n) idx = idx - (RR_IDX_W + 1)'(n);
            if (valid[idx[RR_IDX_W-2:0]]) begin
               pick.found = 1'b1;
               pick.index = idx[RR_IDX_W-1:0];
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// Round-robin candidate selection; owns the rotating priority pointer.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [N-1:0]  i_in_valid,
   input  logic          i_advance,
   output logic [SW-1:0] o_cand,
   output logic          o_found
);

   logic [SW-1:0] r_rr_ptr;
   rr_pick_t      w_pick;

   assign w_pick  = rr_pick(RR_MAX_N'(i_in_valid), RR_IDX_W'(r_rr_ptr), N);
   // The range guard can never trip, but it keeps the wide index fully consumed.
   assign o_found = w_pick.found && (w_pick.index < RR_IDX_W'(N));
   assign o_cand  = SW'(w_pick.index);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr <= '0;
      end else if (i_advance) begin
         r_rr_ptr <= (o_cand == SW'(N - 1)) ? '0 : o_cand + 1'b1;
      end
   end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready mux with registered output; direct select or round-robin grant.
module mux_nx1_rr
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 32,
   localparam int SW = $clog2(N)
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_mode,
   input  logic [SW-1:0]  i_sel,
   input  logic [N*W-1:0] i_in,
   input  logic [N-1:0]   i_in_valid,
   output logic [N-1:0]   o_in_ready,
   output logic [W-1:0]   o_out,
   output logic [SW-1:0]  o_out_sel,
   output logic           o_out_valid,
   input  logic           i_out_ready
);

   logic [W-1:0]  r_out;
   logic [SW-1:0] r_out_sel;
   logic          r_out_valid;

   logic          w_can_load;
   logic          w_dir_found;
   logic          w_rr_found;
   logic          w_found;
   logic          w_xfer;
   logic [SW-1:0] w_rr_cand;
   logic [SW-1:0] w_cand;
   logic [N-1:0]  w_ready;
   logic [W-1:0]  w_data;

   rr_arbiter #(.N(N)) u_arb (
      .i_clk      (i_clk),
      .i_rst_n    (i_reset),
      .i_in_valid (i_in_valid),
      .i_advance  (w_xfer && (i_mode == MODE_RR)),
      .o_cand     (w_rr_cand),
      .o_found    (w_rr_found)
   );

   assign w_can_load  = !r_out_valid || i_out_ready;
   assign w_dir_found = int'(i_sel) < N;
   assign w_cand      = (i_mode == MODE_RR) ? w_rr_cand  : i_sel;
   assign w_found     = (i_mode == MODE_RR) ? w_rr_found : w_dir_found;

   // Ready is gated by reset directly so no channel sees a grant while held in reset.
   always_comb begin
      w_ready = '0;
      if (w_found && w_can_load && i_reset) w_ready[w_cand] = 1'b1;
   end

   assign w_xfer = |(w_ready & i_in_valid);
   assign w_data = i_in[int'(w_cand)*W +: W];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_out       <= '0;
         r_out_sel   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_out       <= w_data;
         r_out_sel   <= w_cand;
         r_out_valid <= 1'b1;
      end else if (w_can_load) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_in_ready  = w_ready;
   assign o_out       = r_out;
   assign o_out_sel   = r_out_sel;
   assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: directed scenarios plus randomized traffic against a cycle model.
module tb_mux_nx1_rr;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           mode = 1'b0;
   logic [SW-1:0]  sel = '0;
   logic [N*W-1:0] din = '0;
   logic [N-1:0]   vin = '0;
   logic [N-1:0]   rdy;
   logic [W-1:0]   dout;
   logic [SW-1:0]  dsel;
   logic           dvalid;
   logic           oready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   int           m_ptr;
   logic [W-1:0] m_out;
   int           m_sel;
   logic         m_valid;
   logic [N-1:0] exp_rdy;
   logic [N-1:0] obs_rdy;

   always #5 clk = ~clk;

   mux_nx1_rr #(.N(N), .W(W)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_mode      (mode),
      .i_sel       (sel),
      .i_in        (din),
      .i_in_valid  (vin),
      .o_in_ready  (rdy),
      .o_out       (dout),
      .o_out_sel   (dsel),
      .o_out_valid (dvalid),
      .i_out_ready (oready)
   );

   function automatic int model_cand();
      if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
      for (int k = 0; k < N; k++)
         if (vin[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_out = '0; m_sel = 0; m_valid = 1'b0;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) din[i*W +: W] = $urandom;
   endtask

   // Samples ready before the edge, advances the model across the edge, returns at edge+1.
   task automatic tick();
      int   c;
      logic can;
      logic xfer;
      #2;
      c   = model_cand();
      can = !m_valid || oready;
      exp_rdy = '0;
      if (c >= 0 && can) exp_rdy[c] = 1'b1;
      obs_rdy = rdy;
      xfer = (c >= 0) && can && vin[c];
      @(posedge clk);
      if (xfer) begin
         m_out = din[c*W +: W]; m_sel = c; m_valid = 1'b1;
         if (mode) m_ptr = (c + 1) % N;
      end else if (can) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b1; vin = 4'b1111; oready = 1'b0;
      rand_data();
      model_reset();
      #22;
      n_checks++; if (dvalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dvalid); else n_pass++;
      n_checks++; if (rdy !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", rdy); else n_pass++;
      n_checks++; if (dout !== '0 || dsel !== '0) $display("FAIL reset_out: got %h/%0d want 0/0", dout, dsel); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1; oready = 1'b1;
      tick();
      n_checks++; if (obs_rdy !== 4'b0001) $display("FAIL release_ready: got %b want 0001", obs_rdy); else n_pass++;
      n_checks++;
      if (dout !== din[0 +: W] || dsel !== 2'd0 || dvalid !== 1'b1)
         $display("FAIL release_out: got %h/%0d/%b want %h/0/1", dout, dsel, dvalid, din[0 +: W]);
      else n_pass++;
   endtask

   task automatic test_direct();
      mode = 1'b0; sel = 2'd2; vin = 4'b1111; oready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         din[2*W +: W] = 32'hA5A5_0002;
         tick();
         n_checks++; if (obs_rdy !== 4'b0100) $display("FAIL direct_ready: got %b want 0100", obs_rdy); else n_pass++;
         n_checks++;
         if (dout !== 32'hA5A5_0002 || dsel !== 2'd2 || dvalid !== 1'b1)
            $display("FAIL direct_out: got %h/%0d/%b want a5a50002/2/1", dout, dsel, dvalid);
         else n_pass++;
      end
   endtask

   task automatic test_rr_fairness();
      do_reset();
      mode = 1'b1; vin = 4'b1111; oready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_data();
         tick();
         n_checks++; if (obs_rdy !== exp_rdy) $display("FAIL rr_ready: got %b want %b", obs_rdy, exp_rdy); else n_pass++;
         n_checks++;
         if (dsel !== SW'(i % N) || dvalid !== 1'b1 || dout !== m_out)
            $display("FAIL rr_seq[%0d]: got %0d/%b/%h want %0d/1/%h", i, dsel, dvalid, dout, i % N, m_out);
         else n_pass++;
      end
   endtask

   task automatic test_sparse_wrap();
      int exp_g [5] = '{1, 3, 1, 3, 0};
      do_reset();
      mode = 1'b1; oready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vin = (i < 4) ? 4'b1010 : 4'b0001;
         rand_data();
         tick();
         n_checks++;
         if (dsel !== SW'(exp_g[i]) || dvalid !== 1'b1 || dout !== m_out)
            $display("FAIL sparse_grant[%0d]: got %0d/%b/%h want %0d/1/%h", i, dsel, dvalid, dout, exp_g[i], m_out);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  hold_out;
      logic [SW-1:0] hold_sel;
      do_reset();
      mode = 1'b1; vin = 4'b1111; oready = 1'b1;
      rand_data();
      tick();
      hold_out = m_out; hold_sel = SW'(m_sel);
      oready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         tick();
         n_checks++; if (obs_rdy !== 4'b0000) $display("FAIL stall_ready: got %b want 0000", obs_rdy); else n_pass++;
         n_checks++;
         if (dout !== hold_out || dsel !== hold_sel || dvalid !== 1'b1)
            $display("FAIL stall_hold: got %h/%0d/%b want %h/%0d/1", dout, dsel, dvalid, hold_out, hold_sel);
         else n_pass++;
      end
      oready = 1'b1;
      rand_data();
      tick();
      n_checks++; if (obs_rdy !== 4'b0010) $display("FAIL unstall_ready: got %b want 0010", obs_rdy); else n_pass++;
      n_checks++;
      if (dout !== m_out || dsel !== 2'd1 || dvalid !== 1'b1)
         $display("FAIL unstall_out: got %h/%0d/%b want %h/1/1", dout, dsel, dvalid, m_out);
      else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      mode = 1'b1; vin = 4'b1111; oready = 1'b1;
      rand_data(); tick();
      rand_data(); tick();
      oready = 1'b0;
      tick();
      n_checks++; if (dsel !== 2'd1 || dvalid !== 1'b1) $display("FAIL pre_reset_stall: got %0d/%b want 1/1", dsel, dvalid); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dvalid !== 1'b0 || rdy !== 4'b0000 || dout !== '0)
         $display("FAIL async_reset: got %b/%b/%h want 0/0000/0", dvalid, rdy, dout);
      else n_pass++;
      model_reset();
      #1;
      rst_n = 1'b1; oready = 1'b1;
      rand_data();
      tick();
      n_checks++; if (obs_rdy !== 4'b0001) $display("FAIL post_reset_ready: got %b want 0001", obs_rdy); else n_pass++;
      n_checks++; if (dsel !== 2'd0 || dout !== din[0 +: W]) $display("FAIL post_reset_grant: got %0d/%h want 0/%h", dsel, dout, din[0 +: W]); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         mode   = 1'($urandom_range(0, 1));
         sel    = SW'($urandom);
         vin    = N'($urandom);
         oready = ($urandom_range(0, 3) != 0);
         rand_data();
         tick();
         n_checks++; if (obs_rdy !== exp_rdy) $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy); else n_pass++;
         n_checks++; if (dvalid !== m_valid) $display("FAIL rand_valid[%0d]: got %b want %b", i, dvalid, m_valid); else n_pass++;
         if (m_valid) begin
            n_checks++;
            if (dout !== m_out || dsel !== SW'(m_sel))
               $display("FAIL rand_out[%0d]: got %h/%0d want %h/%0d", i, dout, dsel, m_out, m_sel);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_rr_fairness();
      test_sparse_wrap();
      test_backpressure();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
